// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit in front of a word-addressed data memory with no byte strobes.
// SB/SH are read-modify-write. Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module dmem_lsu #(
  parameter int unsigned DMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_ARADDR,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_AWVALID,
  output logic [31:0] MEM_AWADDR,
  output logic [31:0] MEM_WDATA,
  output logic [1:0]  DBG_STATE
);

  // Handshake: a request transfers on a rising CLK edge with REQ_VALID && REQ_READY; REQ_READY is
  // high only in IDLE, and completion is a single-cycle RSP_VALID pulse that cannot be stalled.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] WORDS_LIM = 32'(DMEM_WORDS);

  state_t      state_q, state_d;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr, cap_wdata, buf_word, rdata_q;
  logic [31:0] word_off, word_idx, load_ext, merged;
  logic        underflow, err_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // 33-bit subtraction: the borrow is exactly the addr < BASE_ADDR case.
  assign {underflow, word_off} = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
  assign word_idx = word_off >> 2;

  always_comb begin
    err_c = 1'b0;
    if (cap_we) err_c = cap_f3[2] | (cap_f3[1:0] == 2'b11);
    else        err_c = (cap_f3 == 3'b011) | (cap_f3 == 3'b110) | (cap_f3 == 3'b111);
    if (underflow || (word_idx >= WORDS_LIM)) err_c = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((cap_f3[1:0] == 2'b01) && cap_addr[0]) err_c = 1'b1;
    if ((cap_f3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00)) err_c = 1'b1;
`endif
  end

  always_comb begin
    lane_b = 8'h00;
    case (cap_addr[1:0])
      2'd0: lane_b = MEM_RDATA[7:0];
      2'd1: lane_b = MEM_RDATA[15:8];
      2'd2: lane_b = MEM_RDATA[23:16];
      2'd3: lane_b = MEM_RDATA[31:24];
    endcase
    lane_h = cap_addr[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (cap_f3)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_ext = MEM_RDATA;
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = 32'h0;
    endcase
  end

  // Store merge works on the word buffered in ACCESS, so WRITE never depends on MEM_RDATA.
  always_comb begin
    merged = buf_word;
    case (cap_f3[1:0])
      2'b00: begin
        case (cap_addr[1:0])
          2'd0: merged[7:0]   = cap_wdata[7:0];
          2'd1: merged[15:8]  = cap_wdata[7:0];
          2'd2: merged[23:16] = cap_wdata[7:0];
          2'd3: merged[31:24] = cap_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (cap_addr[1]) merged[31:16] = cap_wdata[15:0];
        else             merged[15:0]  = cap_wdata[15:0];
      end
      default: merged = cap_wdata;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= S_IDLE;
      cap_we    <= 1'b0;
      cap_f3    <= 3'b000;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
      buf_word  <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && REQ_VALID) begin
        cap_we    <= REQ_WE;
        cap_f3    <= REQ_FUNCT3;
        cap_addr  <= REQ_ADDR;
        cap_wdata <= REQ_WDATA;
      end
      if (state_q == S_ACCESS) begin
        buf_word <= MEM_RDATA;
        rdata_q  <= (err_c || cap_we) ? 32'h0 : load_ext;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    REQ_READY   = 1'b0;
    MEM_ARADDR  = 32'h0;
    MEM_AWVALID = 1'b0;
    MEM_AWADDR  = 32'h0;
    MEM_WDATA   = 32'h0;
    RSP_VALID   = 1'b0;
    RSP_RDATA   = 32'h0;
    RSP_ERR     = 1'b0;
    case (state_q)
      S_IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        MEM_ARADDR = word_idx;
        state_d    = (cap_we && !err_c) ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        MEM_AWVALID = 1'b1;
        MEM_AWADDR  = word_idx;
        MEM_WDATA   = merged;
        state_d     = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = rdata_q;
        RSP_ERR   = err_c;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DBG_STATE = state_q;

endmodule
